lcd_frame_sequencer: RTL

- Sequences the SPI LCD byte-write engine through the panel power-up and the colour-fill operations.
- Drives the panel reset pin and backlight enable.
- Replays a fixed init command table with embedded delays.
- Once ready, accepts full-screen fill requests and streams window-set commands plus WIDTH×HEIGHT RGB565 pixels.
- Sits between the system control logic and the byte-level SPI writer, which owns lcd_cs, lcd_sclk and lcd_mosi.

---
 rtl/lcd_frame_sequencer.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_frame_sequencer.sv
// Panel power-up, init-table replay and full-screen colour fill for an SPI LCD.
// Feeds a byte-level SPI writer over a valid/ready byte handshake.
module lcd_frame_sequencer #(
   parameter int RST_PULSE_CYC  = 120000,
   parameter int RST_WAIT_CYC   = 1440000,
   parameter int DELAY_UNIT_CYC = 12000,
   parameter int WIDTH          = 128,
   parameter int HEIGHT         = 160
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        fill_req,
   input  logic [15:0] fill_color,
   output logic        fill_ack,
   output logic        busy,
   output logic        init_done,
   output logic        wr_valid,
   output logic [7:0]  wr_data,
   output logic        wr_dc,
   input  logic        wr_ready,
   input  logic        wr_idle,
   output logic        lcd_rst,
   output logic        lcd_led
);

   localparam int DLY_MAX = 255 * DELAY_UNIT_CYC;
   localparam int RST_MAX = (RST_PULSE_CYC > RST_WAIT_CYC) ? RST_PULSE_CYC : RST_WAIT_CYC;
   localparam int CNT_MAX = (RST_MAX > DLY_MAX) ? RST_MAX : DLY_MAX;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int NPIX    = WIDTH * HEIGHT;
   localparam int PW      = $clog2(NPIX + 1);

   localparam logic [CW-1:0] PULSE_LAST = CW'(RST_PULSE_CYC - 1);
   localparam logic [CW-1:0] WAIT_LAST  = CW'(RST_WAIT_CYC - 1);
   localparam logic [PW-1:0] PIX_LAST   = PW'(NPIX - 1);
   localparam logic [15:0]   COL_LAST   = 16'(WIDTH - 1);
   localparam logic [15:0]   ROW_LAST   = 16'(HEIGHT - 1);

   localparam logic [1:0] T_CMD  = 2'd0;
   localparam logic [1:0] T_DATA = 2'd1;
   localparam logic [1:0] T_WAIT = 2'd2;
   localparam logic [1:0] T_END  = 2'd3;

   typedef enum logic [2:0] {
      S_RST_ASSERT, S_RST_WAIT, S_INIT, S_DELAY, S_READY, S_HDR, S_PIX
   } state_t;

   // Init table entry: {type, byte}; anything past the last entry reads as end.
   function automatic logic [9:0] init_entry(input logic [3:0] idx);
      case (idx)
         4'd0:    init_entry = {T_CMD,  8'h01};
         4'd1:    init_entry = {T_WAIT, 8'd150};
         4'd2:    init_entry = {T_CMD,  8'h11};
         4'd3:    init_entry = {T_WAIT, 8'd120};
         4'd4:    init_entry = {T_CMD,  8'h3A};
         4'd5:    init_entry = {T_DATA, 8'h05};
         4'd6:    init_entry = {T_CMD,  8'h36};
         4'd7:    init_entry = {T_DATA, 8'h00};
         4'd8:    init_entry = {T_CMD,  8'h29};
         default: init_entry = {T_END,  8'h00};
      endcase
   endfunction

   // Window-set header: {dc, byte}.
   function automatic logic [8:0] hdr_entry(input logic [3:0] idx);
      case (idx)
         4'd0:    hdr_entry = {1'b0, 8'h2A};
         4'd1:    hdr_entry = {1'b1, 8'h00};
         4'd2:    hdr_entry = {1'b1, 8'h00};
         4'd3:    hdr_entry = {1'b1, COL_LAST[15:8]};
         4'd4:    hdr_entry = {1'b1, COL_LAST[7:0]};
         4'd5:    hdr_entry = {1'b0, 8'h2B};
         4'd6:    hdr_entry = {1'b1, 8'h00};
         4'd7:    hdr_entry = {1'b1, 8'h00};
         4'd8:    hdr_entry = {1'b1, ROW_LAST[15:8]};
         4'd9:    hdr_entry = {1'b1, ROW_LAST[7:0]};
         default: hdr_entry = {1'b0, 8'h2C};
      endcase
   endfunction

   state_t        state_r;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] target_r;
   logic          idle_seen_r;
   logic [3:0]    idx_r;
   logic [3:0]    hdr_idx_r;
   logic [PW-1:0] pix_cnt_r;
   logic          byte_lo_r;
   logic [15:0]   color_r;

   logic [9:0] cur_entry_s;
   logic [9:0] nxt_entry_s;
   logic [8:0] nxt_hdr_s;
   logic [9:0] first_entry_s;

   assign cur_entry_s   = init_entry(idx_r);
   assign nxt_entry_s   = init_entry(idx_r + 4'd1);
   assign nxt_hdr_s     = hdr_entry(hdr_idx_r + 4'd1);
   assign first_entry_s = init_entry(4'd0);

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_r     <= S_RST_ASSERT;
         cnt_r       <= '0;
         target_r    <= '0;
         idle_seen_r <= 1'b0;
         idx_r       <= 4'd0;
         hdr_idx_r   <= 4'd0;
         pix_cnt_r   <= '0;
         byte_lo_r   <= 1'b0;
         color_r     <= 16'h0000;
         fill_ack    <= 1'b0;
         busy        <= 1'b1;
         init_done   <= 1'b0;
         wr_valid    <= 1'b0;
         wr_data     <= 8'h00;
         wr_dc       <= 1'b0;
         lcd_rst     <= 1'b0;
         lcd_led     <= 1'b0;
      end else begin
         fill_ack <= 1'b0;
         case (state_r)
            S_RST_ASSERT: begin
               if (cnt_r == PULSE_LAST) begin
                  cnt_r   <= '0;
                  lcd_rst <= 1'b1;
                  state_r <= S_RST_WAIT;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            S_RST_WAIT: begin
               // The first table entry is a command, so it is presented on the way out.
               if (cnt_r == WAIT_LAST) begin
                  cnt_r    <= '0;
                  idx_r    <= 4'd0;
                  wr_valid <= 1'b1;
                  wr_data  <= first_entry_s[7:0];
                  wr_dc    <= (first_entry_s[9:8] == T_DATA);
                  state_r  <= S_INIT;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            S_INIT: begin
               if (wr_valid) begin
                  if (wr_ready) begin
                     idx_r <= idx_r + 4'd1;
                     if (nxt_entry_s[9:8] == T_CMD || nxt_entry_s[9:8] == T_DATA) begin
                        wr_data <= nxt_entry_s[7:0];
                        wr_dc   <= (nxt_entry_s[9:8] == T_DATA);
                     end else begin
                        wr_valid <= 1'b0;
                     end
                  end
               end else begin
                  case (cur_entry_s[9:8])
                     T_CMD, T_DATA: begin
                        wr_valid <= 1'b1;
                        wr_data  <= cur_entry_s[7:0];
                        wr_dc    <= (cur_entry_s[9:8] == T_DATA);
                     end
                     T_WAIT: begin
                        cnt_r       <= '0;
                        idle_seen_r <= 1'b0;
                        target_r    <= CW'(cur_entry_s[7:0]) * CW'(DELAY_UNIT_CYC);
                        state_r     <= S_DELAY;
                     end
                     default: begin
                        if (wr_idle) begin
                           init_done <= 1'b1;
                           lcd_led   <= 1'b1;
                           busy      <= 1'b0;
                           state_r   <= S_READY;
                        end
                     end
                  endcase
               end
            end
            S_DELAY: begin
               // Counting is held off until the writer has drained the preceding command.
               if (idle_seen_r || wr_idle) begin
                  idle_seen_r <= 1'b1;
                  if (cnt_r == target_r) begin
                     cnt_r   <= '0;
                     idx_r   <= idx_r + 4'd1;
                     state_r <= S_INIT;
                  end else begin
                     cnt_r <= cnt_r + CW'(1);
                  end
               end
            end
            S_READY: begin
               if (fill_req) begin
                  color_r   <= fill_color;
                  fill_ack  <= 1'b1;
                  hdr_idx_r <= 4'd0;
                  busy      <= 1'b1;
                  state_r   <= S_HDR;
               end
            end
            S_HDR: begin
               if (!wr_valid) begin
                  wr_valid         <= 1'b1;
                  {wr_dc, wr_data} <= hdr_entry(hdr_idx_r);
               end else if (wr_ready) begin
                  if (hdr_idx_r == 4'd10) begin
                     pix_cnt_r <= '0;
                     byte_lo_r <= 1'b0;
                     wr_dc     <= 1'b1;
                     wr_data   <= color_r[15:8];
                     state_r   <= S_PIX;
                  end else begin
                     hdr_idx_r        <= hdr_idx_r + 4'd1;
                     {wr_dc, wr_data} <= nxt_hdr_s;
                  end
               end
            end
            S_PIX: begin
               if (wr_ready) begin
                  if (!byte_lo_r) begin
                     byte_lo_r <= 1'b1;
                     wr_data   <= color_r[7:0];
                  end else if (pix_cnt_r == PIX_LAST) begin
                     wr_valid <= 1'b0;
                     busy     <= 1'b0;
                     state_r  <= S_READY;
                  end else begin
                     pix_cnt_r <= pix_cnt_r + PW'(1);
                     byte_lo_r <= 1'b0;
                     wr_data   <= color_r[15:8];
                  end
               end
            end
            default: begin
               state_r <= S_RST_ASSERT;
            end
         endcase
      end
   end

endmodule
